// File: rtl/bcd2bin_pkg.sv
// Shared types and elaboration-time helpers for the BCD <-> binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B2N  = 2'd1,
        ST_N2B  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_B2N = 1'b0,
        MODE_N2B = 1'b1
    } mode_e;

    localparam int          NIB_W   = 4;
    localparam logic [3:0]  ADJ_MIN = 4'd5;
    localparam logic [3:0]  ADJ_ADD = 4'd3;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Smallest binary width able to hold every value 0 .. 10^n - 1.
    function automatic int calc_bin_w(input int num_digits);
        return $clog2(pow10(num_digits));
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [NIB_W-1:0] nib_in,
    output logic [NIB_W-1:0] nib_out
);

    always_comb begin
        nib_out = (nib_in >= ADJ_MIN) ? nib_in + ADJ_ADD : nib_in;
    end

endmodule

// File: rtl/bcd2bin_multi.sv
// Multi-digit BCD <-> binary converter: digit-serial multiply-by-ten one way,
// bit-serial double-dabble the other, sharing one step counter.
module bcd2bin_multi
    import bcd2bin_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int BIN_W      = calc_bin_w(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    ready,
    output logic                    done_tick,
    output logic                    err,
    output logic [BIN_W-1:0]        bin_out,
    output logic [4*NUM_DIGITS-1:0] bcd_out
);

    localparam int BCD_W     = NIB_W * NUM_DIGITS;
    localparam int MAX_STEPS = (NUM_DIGITS > BIN_W) ? NUM_DIGITS : BIN_W;
    localparam int CNT_W     = $clog2(MAX_STEPS + 1);

    localparam logic [CNT_W-1:0] B2N_STEPS = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] N2B_STEPS = CNT_W'(BIN_W);
    localparam logic [BIN_W-1:0] BIN_LIMIT = BIN_W'(pow10(NUM_DIGITS));

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 9) begin : g_bad_digits
            $error("bcd2bin_multi: NUM_DIGITS must be in 1..9");
        end
    endgenerate

    state_e             state_q,     state_d;
    logic [BCD_W-1:0]   bcd_op_q,    bcd_op_d;
    logic [BIN_W-1:0]   bin_op_q,    bin_op_d;
    logic [BIN_W-1:0]   bin_acc_q,   bin_acc_d;
    logic [BCD_W-1:0]   bcd_acc_q,   bcd_acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ready_q,     ready_d;
    logic               done_tick_q, done_tick_d;
    logic               err_q,       err_d;
    logic [BIN_W-1:0]   bin_out_q,   bin_out_d;
    logic [BCD_W-1:0]   bcd_out_q,   bcd_out_d;

    logic               digit_bad;
    logic               bin_too_big;
    logic [BIN_W+3:0]   acc_ext;
    logic [BIN_W+3:0]   acc_x10;
    logic [BCD_W-1:0]   bcd_adj;

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[NIB_W*i +: NIB_W] > 4'd9) digit_bad = 1'b1;
        end
    end

    assign bin_too_big = (bin_in >= BIN_LIMIT);

    // acc*10 + next digit, built as (acc<<3)+(acc<<1) with four bits of headroom.
    assign acc_ext = {4'b0000, bin_acc_q};
    assign acc_x10 = (acc_ext << 3) + (acc_ext << 1)
                   + {{BIN_W{1'b0}}, bcd_op_q[BCD_W-1 -: NIB_W]};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_in  (bcd_acc_q[NIB_W*g +: NIB_W]),
            .nib_out (bcd_adj[NIB_W*g +: NIB_W])
        );
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        bcd_op_d    = bcd_op_q;
        bin_op_d    = bin_op_q;
        bin_acc_d   = bin_acc_q;
        bcd_acc_d   = bcd_acc_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        done_tick_d = 1'b0;
        err_d       = err_q;
        bin_out_d   = bin_out_q;
        bcd_out_d   = bcd_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bcd_op_d  = bcd_in;
                    bin_op_d  = bin_in;
                    bin_acc_d = '0;
                    bcd_acc_d = '0;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    if (mode_e'(mode) == MODE_B2N) begin
                        if (digit_bad) begin
                            state_d     = ST_DONE;
                            done_tick_d = 1'b1;
                            err_d       = 1'b1;
                            bin_out_d   = '0;
                        end else begin
                            state_d = ST_B2N;
                        end
                    end else begin
                        if (bin_too_big) begin
                            state_d     = ST_DONE;
                            done_tick_d = 1'b1;
                            err_d       = 1'b1;
                            bcd_out_d   = '0;
                        end else begin
                            state_d = ST_N2B;
                        end
                    end
                end
            end

            ST_B2N: begin
                if (cnt_q == B2N_STEPS) begin
                    state_d     = ST_DONE;
                    done_tick_d = 1'b1;
                    err_d       = 1'b0;
                    bin_out_d   = bin_acc_q;
                end else begin
                    bin_acc_d = acc_x10[BIN_W-1:0];
                    bcd_op_d  = bcd_op_q << NIB_W;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            ST_N2B: begin
                if (cnt_q == N2B_STEPS) begin
                    state_d     = ST_DONE;
                    done_tick_d = 1'b1;
                    err_d       = 1'b0;
                    bcd_out_d   = bcd_acc_q;
                end else begin
                    bcd_acc_d = {bcd_adj[BCD_W-2:0], bin_op_q[BIN_W-1]};
                    bin_op_d  = bin_op_q << 1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state is written with <= only, and the reset clears every flop including the datapath.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bcd_op_q    <= '0;
            bin_op_q    <= '0;
            bin_acc_q   <= '0;
            bcd_acc_q   <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            done_tick_q <= 1'b0;
            err_q       <= 1'b0;
            bin_out_q   <= '0;
            bcd_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            bcd_op_q    <= bcd_op_d;
            bin_op_q    <= bin_op_d;
            bin_acc_q   <= bin_acc_d;
            bcd_acc_q   <= bcd_acc_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            done_tick_q <= done_tick_d;
            err_q       <= err_d;
            bin_out_q   <= bin_out_d;
            bcd_out_q   <= bcd_out_d;
        end
    end

    assign ready     = ready_q;
    assign done_tick = done_tick_q;
    assign err       = err_q;
    assign bin_out   = bin_out_q;
    assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_bcd2bin_multi.sv
// Scoreboard bench for bcd2bin_multi: a 2-digit and a 4-digit instance checked
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd2bin_multi;

    localparam int NDUT = 2;
    localparam int ND [NDUT] = '{2, 4};
    localparam int BW [NDUT] = '{7, 14};

    typedef struct { bit err; longint bin; longint bcd; } res_t;
    typedef struct { res_t res; longint due; } exp_t;

    logic   clk = 1'b0;
    longint cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_s   [NDUT];
    logic        start_s   [NDUT];
    logic        mode_s    [NDUT];
    logic [35:0] bcd_in_s  [NDUT];
    logic [31:0] bin_in_s  [NDUT];
    logic        ready_s   [NDUT];
    logic        done_s    [NDUT];
    logic        err_s     [NDUT];
    logic [31:0] bin_out_s [NDUT];
    logic [35:0] bcd_out_s [NDUT];

    logic        a_ready, a_done, a_err;
    logic [6:0]  a_bin;
    logic [7:0]  a_bcd;
    logic        b_ready, b_done, b_err;
    logic [13:0] b_bin;
    logic [15:0] b_bcd;

    bcd2bin_multi #(.NUM_DIGITS(2)) dut_a (
        .clk       (clk),
        .reset     (reset_s[0]),
        .start     (start_s[0]),
        .mode      (mode_s[0]),
        .bcd_in    (bcd_in_s[0][7:0]),
        .bin_in    (bin_in_s[0][6:0]),
        .ready     (a_ready),
        .done_tick (a_done),
        .err       (a_err),
        .bin_out   (a_bin),
        .bcd_out   (a_bcd)
    );

    bcd2bin_multi #(.NUM_DIGITS(4)) dut_b (
        .clk       (clk),
        .reset     (reset_s[1]),
        .start     (start_s[1]),
        .mode      (mode_s[1]),
        .bcd_in    (bcd_in_s[1][15:0]),
        .bin_in    (bin_in_s[1][13:0]),
        .ready     (b_ready),
        .done_tick (b_done),
        .err       (b_err),
        .bin_out   (b_bin),
        .bcd_out   (b_bcd)
    );

    always_comb begin
        ready_s[0]   = a_ready;
        done_s[0]    = a_done;
        err_s[0]     = a_err;
        bin_out_s[0] = {25'h0, a_bin};
        bcd_out_s[0] = {28'h0, a_bcd};
        ready_s[1]   = b_ready;
        done_s[1]    = b_done;
        err_s[1]     = b_err;
        bin_out_s[1] = {18'h0, b_bin};
        bcd_out_s[1] = {20'h0, b_bcd};
    end

    exp_t   sb       [NDUT][$];
    longint done_cyc [NDUT][$];
    res_t   prev     [NDUT];
    int     done_cnt [NDUT];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain decimal arithmetic on the digit values.
    function automatic res_t model(input int n, input bit m, input logic [35:0] bcd,
                                   input longint bin, input res_t old);
        res_t   r;
        longint lim, p, v, d;
        bit     bad;
        r   = old;
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        if (!m) begin
            bad = 1'b0;
            v   = 0;
            p   = 1;
            for (int i = 0; i < n; i++) begin
                d = longint'(bcd[4*i +: 4]);
                if (d > 9) bad = 1'b1;
                v = v + d * p;
                p = p * 10;
            end
            r.err = bad;
            r.bin = bad ? 0 : v;
        end else begin
            r.err = (bin >= lim);
            r.bcd = 0;
            if (!r.err) begin
                for (int i = 0; i < n; i++) begin
                    r.bcd = r.bcd | ((bin % 10) << (4 * i));
                    bin   = bin / 10;
                end
            end
        end
        return r;
    endfunction

    // Edges from acceptance to the edge that raises done_tick.
    function automatic int lat_of(input int d, input bit m, input res_t res);
        if (res.err) return 0;
        return m ? BW[d] + 1 : ND[d] + 1;
    endfunction

    function automatic logic [35:0] rand_bcd(input int n);
        logic [35:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[4*i +: 4] = 4'($urandom_range(0, 11));
        return v;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done_s[d] === 1'b1) begin
                exp_t e;
                done_cnt[d]++;
                done_cyc[d].push_back(cyc);
                if (sb[d].size() == 0) begin
                    check($sformatf("d%0d_unexpected_done", d), done_s[d], 1'b0);
                end else begin
                    e = sb[d].pop_front();
                    check($sformatf("d%0d_done_cycle", d), cyc, e.due);
                    check($sformatf("d%0d_err", d), err_s[d], e.res.err);
                    check($sformatf("d%0d_bin_out", d), bin_out_s[d], e.res.bin);
                    check($sformatf("d%0d_bcd_out", d), bcd_out_s[d], e.res.bcd);
                    check($sformatf("d%0d_ready_in_done", d), ready_s[d], 1'b0);
                end
            end
        end
    end

    task automatic issue(input int d, input bit m, input logic [35:0] bcd,
                         input longint bin, input bit hold);
        int   g;
        res_t res;
        g = 0;
        while (ready_s[d] !== 1'b1 && g < 400) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("d%0d_ready_wait", d), ready_s[d], 1'b1);
        mode_s[d]   = m;
        bcd_in_s[d] = bcd;
        bin_in_s[d] = 32'(bin);
        start_s[d]  = 1'b1;
        res     = model(ND[d], m, bcd, bin, prev[d]);
        prev[d] = res;
        sb[d].push_back('{res: res, due: cyc + 1 + lat_of(d, m, res)});
        @(negedge clk);
        if (!hold) start_s[d] = 1'b0;
        mode_s[d]   = 1'($urandom);
        bcd_in_s[d] = {4'h0, $urandom};
        bin_in_s[d] = $urandom;
    endtask

    task automatic drain(input int d);
        int g;
        g = 0;
        while (sb[d].size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("d%0d_drain", d), sb[d].size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int d = 0; d < NDUT; d++) begin
            reset_s[d]  = 1'b0;
            start_s[d]  = 1'b0;
            mode_s[d]   = 1'b0;
            bcd_in_s[d] = '0;
            bin_in_s[d] = '0;
            prev[d]     = '{err: 1'b0, bin: 0, bcd: 0};
            done_cnt[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rst_ready", d), ready_s[d], 1'b1);
            check($sformatf("d%0d_rst_done", d), done_s[d], 1'b0);
            check($sformatf("d%0d_rst_err", d), err_s[d], 1'b0);
            check($sformatf("d%0d_rst_bin_out", d), bin_out_s[d], 0);
            check($sformatf("d%0d_rst_bcd_out", d), bcd_out_s[d], 0);
            reset_s[d] = 1'b1;
        end
        @(negedge clk);

        issue(0, 1'b0, 36'h55, 0, 1'b0);
        issue(0, 1'b1, 36'h0, 'h63, 1'b0);
        issue(0, 1'b0, 36'h99, 0, 1'b0);
        issue(0, 1'b0, 36'h5A, 0, 1'b0);
        issue(0, 1'b1, 36'h0, 100, 1'b0);
        issue(0, 1'b1, 36'h0, 99, 1'b0);
        issue(0, 1'b0, 36'h00, 0, 1'b0);
        issue(0, 1'b1, 36'h0, 0, 1'b0);
        issue(0, 1'b1, 36'h0, 127, 1'b0);
        drain(0);

        issue(1, 1'b0, 36'h9999, 0, 1'b0);
        issue(1, 1'b1, 36'h0, 'h270F, 1'b0);
        issue(1, 1'b0, 36'h0000, 0, 1'b0);
        issue(1, 1'b1, 36'h0, 0, 1'b0);
        issue(1, 1'b1, 36'h0, 10000, 1'b0);
        issue(1, 1'b0, 36'h9A99, 0, 1'b0);
        drain(1);

        for (int i = 0; i < 20; i++)
            issue(0, 1'($urandom), rand_bcd(2), longint'($urandom_range(0, 127)), 1'b0);
        drain(0);
        for (int i = 0; i < 12; i++)
            issue(1, 1'($urandom), rand_bcd(4), longint'($urandom_range(0, 16383)), 1'b0);
        drain(1);

        // A second start pulse while converting must be ignored.
        issue(0, 1'b0, 36'h47, 0, 1'b0);
        n = done_cnt[0];
        start_s[0]  = 1'b1;
        mode_s[0]   = 1'b1;
        bin_in_s[0] = 32'd5;
        @(negedge clk);
        start_s[0] = 1'b0;
        drain(0);
        check("d0_single_done", done_cnt[0], n + 1);

        // start held high: three operations back to back.
        done_cyc[0].delete();
        issue(0, 1'b0, 36'h12, 0, 1'b1);
        issue(0, 1'b0, 36'h34, 0, 1'b1);
        issue(0, 1'b0, 36'h56, 0, 1'b1);
        start_s[0] = 1'b0;
        drain(0);
        check("d0_hold_done_count", done_cyc[0].size(), 3);
        check("d0_hold_spacing_1", done_cyc[0][1] - done_cyc[0][0], ND[0] + 1 + 2);
        check("d0_hold_spacing_2", done_cyc[0][2] - done_cyc[0][1], ND[0] + 1 + 2);

        // Reset in the middle of a binary->BCD conversion.
        issue(0, 1'b1, 36'h0, 77, 1'b0);
        repeat (3) @(negedge clk);
        reset_s[0] = 1'b0;
        sb[0].delete();
        prev[0] = '{err: 1'b0, bin: 0, bcd: 0};
        n = done_cnt[0];
        @(negedge clk);
        reset_s[0] = 1'b1;
        check("d0_abort_ready", ready_s[0], 1'b1);
        check("d0_abort_done", done_s[0], 1'b0);
        check("d0_abort_err", err_s[0], 1'b0);
        check("d0_abort_bin_out", bin_out_s[0], 0);
        check("d0_abort_bcd_out", bcd_out_s[0], 0);
        repeat (BW[0] + 6) @(negedge clk);
        check("d0_abort_no_done", done_cnt[0], n);

        issue(0, 1'b0, 36'h81, 0, 1'b0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
